// File: rtl/raizing_snd_pkg.sv
// Shared constants and types for the 68k-to-Z80 sound command mailbox.
package raizing_snd_pkg;
    localparam int IRQ_LEVEL   = 0;
    localparam int IRQ_LATCHED = 1;
    localparam int ACK_OFF     = 0;
    localparam int ACK_ON      = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } busy_st_e;
endpackage

// File: rtl/raizing_snd_mailbox_if.sv
// Main-CPU and sound-CPU facing signals of the mailbox, one bundle per board.
interface raizing_snd_mailbox_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          MAIN_WR;
    logic [DW-1:0] MAIN_DIN;
    logic          MAIN_BUSY;
    logic [DW-1:0] MAIN_REPLY;
    logic          Z80_RD;
    logic [DW-1:0] Z80_DOUT;
    logic          Z80_ACK;
    logic          Z80_REPLY_WR;
    logic [DW-1:0] Z80_REPLY_DIN;
    logic          Z80_IACK;
    logic          Z80_INT_N;
    logic [AW:0]   LEVEL;
    logic          OVERRUN;

    modport master (
        output MAIN_WR, MAIN_DIN, Z80_RD, Z80_ACK, Z80_REPLY_WR, Z80_REPLY_DIN, Z80_IACK,
        input  MAIN_BUSY, MAIN_REPLY, Z80_DOUT, Z80_INT_N, LEVEL, OVERRUN
    );
    modport slave (
        input  MAIN_WR, MAIN_DIN, Z80_RD, Z80_ACK, Z80_REPLY_WR, Z80_REPLY_DIN, Z80_IACK,
        output MAIN_BUSY, MAIN_REPLY, Z80_DOUT, Z80_INT_N, LEVEL, OVERRUN
    );
endinterface

// File: rtl/raizing_snd_fifo.sv
// Synchronous command FIFO with a registered fall-through head and a
// look-ahead of next-cycle full/empty for the mailbox's registered flags.
module raizing_snd_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [AW:0]   level_o,
    output logic          push_ok_o,
    output logic          full_nxt_o,
    output logic          empty_nxt_o
);
    localparam int DEPTH = 1 << AW;
    // AW=0 still needs a 1-bit pointer; the spare entry is never addressed.
    localparam int PW    = (AW == 0) ? 1 : AW;
    localparam int MEMN  = 1 << PW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [MEMN-1:0][DW-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             level_q, level_d;
    logic [DW-1:0]           dout_q, dout_d;
    logic                    full, empty, pop_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (AW == 0) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full      = (level_q == FULL_LVL);
        empty     = (level_q == '0);
        // a pop in the same cycle frees the slot, so push-while-full is legal
        push_ok_o = push_i && (!full || pop_i);
        pop_ok    = pop_i && !empty;
        wr_d      = push_ok_o ? inc(wr_q) : wr_q;
        rd_d      = pop_ok ? inc(rd_q) : rd_q;
        mem_d     = mem_q;
        if (push_ok_o) mem_d[wr_q] = din_i;
        level_d = level_q;
        if (push_ok_o && !pop_ok)      level_d = level_q + ONE;
        else if (!push_ok_o && pop_ok) level_d = level_q - ONE;
        // reading mem_d gives fall-through when pushing into an empty FIFO
        dout_d = (level_d == '0) ? dout_q : mem_d[rd_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            dout_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            dout_q  <= dout_d;
        end
    end

    assign dout_o      = dout_q;
    assign level_o     = level_q;
    assign full_nxt_o  = (level_d == FULL_LVL);
    assign empty_nxt_o = (level_d == '0);
endmodule

// File: rtl/raizing_snd_mailbox.sv
// 68k-to-Z80 sound command mailbox: command FIFO plus Z80 interrupt,
// main-CPU busy handshake, reply latch and sticky overrun flag.
module raizing_snd_mailbox
    import raizing_snd_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int IRQ_MODE = IRQ_LATCHED,
    parameter int ACK_MODE = ACK_ON
) (
    input  logic                 CLK96,
    input  logic                 RESET96_N,
    raizing_snd_mailbox_if.slave mb
);
    logic          push_ok, full_nxt, empty_nxt, iack_rise;
    logic          iack_s_q, iack_p_q;
    busy_st_e      st_q, st_d;
    logic          busy_q, busy_d, int_n_q, int_n_d, ovr_q, ovr_d;
    logic [DW-1:0] reply_q, reply_d;

    raizing_snd_fifo #(.DW(DW), .AW(AW)) u_fifo (
        .clk         (CLK96),
        .rst_n       (RESET96_N),
        .push_i      (mb.MAIN_WR),
        .pop_i       (mb.Z80_RD),
        .din_i       (mb.MAIN_DIN),
        .dout_o      (mb.Z80_DOUT),
        .level_o     (mb.LEVEL),
        .push_ok_o   (push_ok),
        .full_nxt_o  (full_nxt),
        .empty_nxt_o (empty_nxt)
    );

    always_comb begin
        iack_rise = iack_s_q && !iack_p_q;
        st_d = st_q;
        if (push_ok)          st_d = PENDING;
        else if (mb.Z80_ACK)  st_d = IDLE;
        busy_d = full_nxt || (ACK_MODE == ACK_ON && st_d == PENDING);
        // a push landing on the IACK edge wins so that command is not missed
        if (IRQ_MODE == IRQ_LATCHED)
            int_n_d = push_ok ? 1'b0 : (iack_rise ? 1'b1 : int_n_q);
        else
            int_n_d = empty_nxt;
        ovr_d   = ovr_q || (mb.MAIN_WR && !push_ok);
        reply_d = mb.Z80_REPLY_WR ? mb.Z80_REPLY_DIN : reply_q;
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            iack_s_q <= 1'b0;
            iack_p_q <= 1'b0;
            st_q     <= IDLE;
            busy_q   <= 1'b0;
            int_n_q  <= 1'b1;
            ovr_q    <= 1'b0;
            reply_q  <= '0;
        end else begin
            iack_s_q <= mb.Z80_IACK;
            iack_p_q <= iack_s_q;
            st_q     <= st_d;
            busy_q   <= busy_d;
            int_n_q  <= int_n_d;
            ovr_q    <= ovr_d;
            reply_q  <= reply_d;
        end
    end

    assign mb.MAIN_BUSY  = busy_q;
    assign mb.Z80_INT_N  = int_n_q;
    assign mb.OVERRUN    = ovr_q;
    assign mb.MAIN_REPLY = reply_q;
endmodule
